// File: rtl/breakout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : breakout_pkg
// Brief    : Shared constants for the Breakout game controller.
// Revision : 1.0
// ============================================================================
package breakout_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_OVER  = 3'd3;
    localparam logic [2:0] ST_WON   = 3'd4;

    localparam int NUM_BRICKS      = 5;
    localparam int FRAME_Y_DEFAULT = 481;

endpackage
`default_nettype wire

// File: rtl/breakout_game_ctrl_button_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : button_sync_edge
// Brief    : Two-flop synchronizer followed by a registered rising-edge pulse.
// Revision : 1.0
// ============================================================================
module button_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : breakout_game_ctrl
// Brief    : Game sequencing: bricks, lives, score, serve delay and game FSM.
// Revision : 1.0
// ============================================================================
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int FRAME_Y      = FRAME_Y_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [9:0]            pixelX,
    input  logic [9:0]            pixelY,
    input  logic                  btnStart,
    input  logic                  hitValid,
    input  logic [2:0]            hitIdx,
    input  logic                  ballMiss,
    output logic                  frameTick,
    output logic [NUM_BRICKS-1:0] brickOn,
    output logic                  hitAck,
    output logic                  ballServe,
    output logic                  ballEnable,
    output logic [2:0]            gameState,
    output logic [1:0]            lives,
    output logic [7:0]            score
);

    logic                  start_pulse;
    logic                  frame_cmp;
    logic                  frame_cmp_q;
    logic                  frame_tick_q;

    logic [2:0]            state_q,     state_d;
    logic [NUM_BRICKS-1:0] brick_q,     brick_d;
    logic [1:0]            lives_q,     lives_d;
    logic [7:0]            score_q,     score_d;
    logic [7:0]            serve_cnt_q, serve_cnt_d;
    logic                  hit_ack_q;
    logic                  serve_q;
    logic                  enable_q;

    logic                  hit_in_range;
    logic [NUM_BRICKS-1:0] hit_mask;
    logic                  hit_ok;
    logic                  hit_wins;

    button_sync_edge u_start_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .btn_i   (btnStart),
        .pulse_o (start_pulse)
    );

    // Edge of the compare, so a pixel held for several clocks ticks once.
    assign frame_cmp = (pixelY == 10'(FRAME_Y)) && (pixelX == 10'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_cmp_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_cmp_q  <= frame_cmp;
            frame_tick_q <= frame_cmp & ~frame_cmp_q;
        end
    end

    // Out-of-range indices give an empty mask and are therefore never accepted.
    assign hit_in_range = (hitIdx < 3'(NUM_BRICKS));
    assign hit_mask     = hit_in_range ? ({{(NUM_BRICKS-1){1'b0}}, 1'b1} << hitIdx)
                                       : '0;
    assign hit_ok       = hitValid && (state_q == ST_PLAY) && ((brick_q & hit_mask) != '0);
    assign hit_wins     = hit_ok && ((brick_q & ~hit_mask) == '0);

    always_comb begin
        state_d     = state_q;
        brick_d     = brick_q;
        lives_d     = lives_q;
        score_d     = score_q;
        serve_cnt_d = serve_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = 8'(SERVE_FRAMES);
                end
            end

            ST_SERVE: begin
                if (frame_tick_q) begin
                    if (serve_cnt_q <= 8'd1) begin
                        serve_cnt_d = 8'd0;
                        state_d     = ST_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q - 8'd1;
                    end
                end
            end

            ST_PLAY: begin
                if (hit_ok) begin
                    brick_d = brick_q & ~hit_mask;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                end
                // A winning hit takes priority and swallows a same-cycle miss.
                if (hit_wins) begin
                    state_d = ST_WON;
                end else if (ballMiss) begin
                    if (lives_q > 2'd1) begin
                        lives_d     = lives_q - 2'd1;
                        state_d     = ST_SERVE;
                        serve_cnt_d = 8'(SERVE_FRAMES);
                    end else begin
                        lives_d = 2'd0;
                        state_d = ST_OVER;
                    end
                end
            end

            ST_OVER, ST_WON: begin
                if (start_pulse) begin
                    state_d = ST_IDLE;
                    brick_d = '1;
                    lives_d = 2'(LIVES);
                    score_d = 8'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            brick_q     <= '1;
            lives_q     <= 2'(LIVES);
            score_q     <= 8'd0;
            serve_cnt_q <= 8'd0;
            hit_ack_q   <= 1'b0;
            serve_q     <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            brick_q     <= brick_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            serve_cnt_q <= serve_cnt_d;
            hit_ack_q   <= hit_ok;
            serve_q     <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
            enable_q    <= (state_d == ST_PLAY);
        end
    end

    assign frameTick  = frame_tick_q;
    assign brickOn    = brick_q;
    assign hitAck     = hit_ack_q;
    assign ballServe  = serve_q;
    assign ballEnable = enable_q;
    assign gameState  = state_q;
    assign lives      = lives_q;
    assign score      = score_q;

endmodule
`default_nettype wire

// File: tb/tb_breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_breakout_game_ctrl
// Brief    : Self-checking bench for breakout_game_ctrl with a game-rule model.
// Revision : 1.0
// ============================================================================
module tb_breakout_game_ctrl;

    localparam int LIVES        = 3;
    localparam int SERVE_FRAMES = 2;
    localparam int FRAME_Y      = 481;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic [9:0] pixelX   = 10'd0;
    logic [9:0] pixelY   = 10'd0;
    logic       btnStart = 1'b0;
    logic       hitValid = 1'b0;
    logic [2:0] hitIdx   = 3'd0;
    logic       ballMiss = 1'b0;

    logic       frameTick;
    logic [4:0] brickOn;
    logic       hitAck;
    logic       ballServe;
    logic       ballEnable;
    logic [2:0] gameState;
    logic [1:0] lives;
    logic [7:0] score;

    int n_tests = 0;
    int n_fail  = 0;
    int serve_pulses = 0;

    // Reference model: game state as plain integers and a per-brick array
    int m_state;
    int m_lives;
    int m_score;
    int m_serve_left;
    bit m_alive [5];
    bit m_tick, m_ack, m_serve, m_enable, m_cmp_prev;
    bit m_btn   [5];

    breakout_game_ctrl #(
        .LIVES        (LIVES),
        .SERVE_FRAMES (SERVE_FRAMES),
        .FRAME_Y      (FRAME_Y)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .btnStart   (btnStart),
        .hitValid   (hitValid),
        .hitIdx     (hitIdx),
        .ballMiss   (ballMiss),
        .frameTick  (frameTick),
        .brickOn    (brickOn),
        .hitAck     (hitAck),
        .ballServe  (ballServe),
        .ballEnable (ballEnable),
        .gameState  (gameState),
        .lives      (lives),
        .score      (score)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (ballServe) serve_pulses++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=2000000", $time);
        $fatal(1);
    end

    function automatic logic [4:0] m_bricks();
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = m_alive[i];
        return b;
    endfunction

    function automatic int m_alive_count();
        int n = 0;
        for (int i = 0; i < 5; i++) n += m_alive[i];
        return n;
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = LIVES; m_score = 0; m_serve_left = 0;
        m_tick = 0; m_ack = 0; m_serve = 0; m_enable = 0; m_cmp_prev = 0;
        for (int i = 0; i < 5; i++) begin m_alive[i] = 1; m_btn[i] = 0; end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        btnStart = 0; hitValid = 0; hitIdx = 0; ballMiss = 0;
        pixelX = 10'd37; pixelY = 10'd100;
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1;
    endtask

    // One clock: drive inputs, advance, update the model. pix: 0 idle, 1 tick pixel, 2 same line other pixel
    task automatic cycle(input bit btn, input bit hv, input int idx, input bit miss, input int pix);
        bit start_seen, tick_seen, accepted, won;
        @(negedge clock);
        btnStart = btn; hitValid = hv; hitIdx = 3'(idx); ballMiss = miss;
        case (pix)
            1:       begin pixelY = 10'(FRAME_Y); pixelX = 10'd0; end
            2:       begin pixelY = 10'(FRAME_Y); pixelX = 10'($urandom_range(1, 799)); end
            default: begin pixelY = 10'd100;      pixelX = 10'd37; end
        endcase
        @(posedge clock);
        for (int i = 4; i > 0; i--) m_btn[i] = m_btn[i-1];
        m_btn[0]   = btn;
        start_seen = m_btn[3] && !m_btn[4];
        tick_seen  = m_tick;
        m_tick     = (pix == 1) && !m_cmp_prev;
        m_cmp_prev = (pix == 1);
        m_ack = 0; m_serve = 0; accepted = 0; won = 0;
        case (m_state)
            0: if (start_seen) begin m_state = 1; m_serve = 1; m_serve_left = SERVE_FRAMES; end
            1: if (tick_seen) begin
                   m_serve_left--;
                   if (m_serve_left == 0) m_state = 2;
               end
            2: begin
                   if (hv && idx < 5) accepted = m_alive[idx];
                   if (accepted) begin
                       m_alive[idx] = 0;
                       if (m_score < 255) m_score++;
                       m_ack = 1;
                       if (m_alive_count() == 0) begin won = 1; m_state = 4; end
                   end
                   if (!won && miss) begin
                       if (m_lives > 1) begin
                           m_lives--; m_state = 1; m_serve = 1; m_serve_left = SERVE_FRAMES;
                       end else begin
                           m_lives = 0; m_state = 3;
                       end
                   end
               end
            default: if (start_seen) begin
                   m_state = 0; m_lives = LIVES; m_score = 0;
                   for (int i = 0; i < 5; i++) m_alive[i] = 1;
               end
        endcase
        m_enable = (m_state == 2);
        #1;
    endtask

    task automatic press_start();
        cycle(1, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic serve_ticks();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic start_game();
        apply_reset();
        press_start();
        serve_ticks();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (gameState !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", gameState); end
        n_tests++; if (brickOn !== 5'b11111) begin n_fail++; $display("FAIL reset_bricks: got %b expected 11111", brickOn); end
        n_tests++; if (lives !== 2'd3 || score !== 8'd0) begin n_fail++; $display("FAIL reset_counters: lives=%0d score=%0d expected 3 0", lives, score); end
        cycle(0, 0, 0, 0, 0);
        n_tests++;
        if ({frameTick, hitAck, ballServe, ballEnable} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {frameTick, hitAck, ballServe, ballEnable});
        end
    endtask

    task automatic test_serve();
        int p0;
        apply_reset();
        p0 = serve_pulses;
        press_start();
        n_tests++; if (gameState !== 3'd1 || ballEnable !== 1'b0) begin n_fail++; $display("FAIL serve_entry: state=%0d en=%0b expected 1 0", gameState, ballEnable); end
        cycle(0, 0, 0, 0, 1);
        n_tests++; if (frameTick !== 1'b1) begin n_fail++; $display("FAIL frame_tick: got %0b expected 1", frameTick); end
        cycle(0, 0, 0, 0, 0);
        n_tests++; if (gameState !== 3'd1) begin n_fail++; $display("FAIL serve_hold: state=%0d expected 1", gameState); end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        n_tests++; if (gameState !== 3'd2 || ballEnable !== 1'b1) begin n_fail++; $display("FAIL serve_to_play: state=%0d en=%0b expected 2 1", gameState, ballEnable); end
        n_tests++; if (serve_pulses - p0 != 1) begin n_fail++; $display("FAIL serve_pulse_count: got %0d expected 1", serve_pulses - p0); end
    endtask

    task automatic test_hits();
        cycle(0, 1, 2, 0, 0);
        n_tests++; if (brickOn !== 5'b11011 || score !== 8'd1 || hitAck !== 1'b1) begin n_fail++; $display("FAIL hit2: bricks=%b score=%0d ack=%0b expected 11011 1 1", brickOn, score, hitAck); end
        cycle(0, 1, 2, 0, 0);
        n_tests++; if (hitAck !== 1'b0 || score !== 8'd1) begin n_fail++; $display("FAIL hit2_repeat: ack=%0b score=%0d expected 0 1", hitAck, score); end
        cycle(0, 1, 6, 0, 0);
        n_tests++; if (hitAck !== 1'b0 || brickOn !== 5'b11011 || score !== 8'd1) begin n_fail++; $display("FAIL hit6_ignored: ack=%0b bricks=%b score=%0d expected 0 11011 1", hitAck, brickOn, score); end
    endtask

    task automatic test_win();
        start_game();
        for (int i = 0; i < 5; i++) cycle(0, 1, i, 0, 0);
        n_tests++; if (gameState !== 3'd4 || score !== 8'd5 || brickOn !== 5'b00000) begin n_fail++; $display("FAIL win: state=%0d score=%0d bricks=%b expected 4 5 00000", gameState, score, brickOn); end
        press_start();
        n_tests++; if (gameState !== 3'd0 || brickOn !== 5'b11111 || score !== 8'd0 || lives !== 2'd3) begin n_fail++; $display("FAIL win_restart: state=%0d bricks=%b score=%0d lives=%0d expected 0 11111 0 3", gameState, brickOn, score, lives); end
    endtask

    task automatic test_misses();
        start_game();
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 1, 0);
            n_tests++;
            if (lives !== 2'(3 - k) || gameState !== ((k < 3) ? 3'd1 : 3'd3) || ballEnable !== 1'b0) begin
                n_fail++; $display("FAIL miss%0d: lives=%0d state=%0d en=%0b expected %0d %0d 0", k, lives, gameState, ballEnable, 3 - k, (k < 3) ? 1 : 3);
            end
            if (k < 3) begin
                n_tests++; if (ballServe !== 1'b1) begin n_fail++; $display("FAIL miss%0d_serve: got %0b expected 1", k, ballServe); end
                serve_ticks();
            end
        end
    endtask

    task automatic test_hit_miss();
        start_game();
        for (int i = 0; i < 4; i++) cycle(0, 1, i, 0, 0);
        repeat (2) begin cycle(0, 0, 0, 1, 0); serve_ticks(); end
        cycle(0, 1, 4, 1, 0);
        n_tests++; if (gameState !== 3'd4 || lives !== 2'd1 || score !== 8'd5) begin n_fail++; $display("FAIL final_hit_miss: state=%0d lives=%0d score=%0d expected 4 1 5", gameState, lives, score); end
        start_game();
        cycle(0, 0, 0, 1, 0);
        serve_ticks();
        cycle(0, 1, 1, 1, 0);
        n_tests++; if (brickOn !== 5'b11101 || lives !== 2'd1 || gameState !== 3'd1 || score !== 8'd1) begin n_fail++; $display("FAIL hit_miss: bricks=%b lives=%0d state=%0d score=%0d expected 11101 1 1 1", brickOn, lives, gameState, score); end
    endtask

    task automatic test_async_reset();
        start_game();
        cycle(0, 1, 1, 0, 0); cycle(0, 1, 3, 0, 0); cycle(0, 1, 4, 0, 0);
        n_tests++; if (brickOn !== 5'b00101 || score !== 8'd3) begin n_fail++; $display("FAIL pre_reset: bricks=%b score=%0d expected 00101 3", brickOn, score); end
        #2 reset_n = 0;
        #1;
        n_tests++;
        if (gameState !== 3'd0 || brickOn !== 5'b11111 || lives !== 2'd3 || score !== 8'd0 ||
            {frameTick, hitAck, ballServe, ballEnable} !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset: state=%0d bricks=%b lives=%0d score=%0d pulses=%b expected 0 11111 3 0 0000",
                               gameState, brickOn, lives, score, {frameTick, hitAck, ballServe, ballEnable});
        end
        model_reset();
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_random();
        bit btn = 0;
        logic [22:0] got, exp;
        start_game();
        repeat (500) begin
            if ($urandom_range(0, 9) == 0) btn = ~btn;
            cycle(btn, ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                  ($urandom_range(0, 11) == 0), $urandom_range(0, 3) == 0 ? 1 : $urandom_range(0, 2) == 0 ? 2 : 0);
            got = {frameTick, brickOn, hitAck, ballServe, ballEnable, gameState, lives, score};
            exp = {m_tick, m_bricks(), m_ack, m_serve, m_enable, 3'(m_state), 2'(m_lives), 8'(m_score)};
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL random_step: got %h expected %h", got, exp); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve();
        test_hits();
        test_win();
        test_misses();
        test_hit_miss();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
